// File: rtl/alu_txn_sequencer.sv
// Issues one packed request on the ALU operand interface and returns the captured result/flags.
// Optional `ALU_SEQ_SPLIT_GAP_EN adds REQ_GAP idle-issue cycles between the halves of a split request.
module alu_txn_sequencer #(
    parameter int OP_WIDTH = 8,
    parameter int RES_LAT  = 2,
    parameter int MUL_LAT  = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_MODE,
    input  logic [3:0]            REQ_CMD,
    input  logic [OP_WIDTH-1:0]   REQ_OPA,
    input  logic [OP_WIDTH-1:0]   REQ_OPB,
    input  logic                  REQ_CIN,
    input  logic                  REQ_SPLIT,
`ifdef ALU_SEQ_SPLIT_GAP_EN
    input  logic [3:0]            REQ_GAP,
`endif
    output logic                  CE,
    output logic                  MODE,
    output logic                  CIN,
    output logic [3:0]            CMD,
    output logic [OP_WIDTH-1:0]   OPA,
    output logic [OP_WIDTH-1:0]   OPB,
    output logic [1:0]            INP_VALID,
    input  logic [2*OP_WIDTH-1:0] RES,
    input  logic                  COUT,
    input  logic                  OFLOW,
    input  logic                  G,
    input  logic                  E,
    input  logic                  L,
    input  logic                  ERR,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [2*OP_WIDTH-1:0] RSP_RES,
    output logic [5:0]            RSP_FLAGS,
    output logic                  RSP_ILLEGAL
);

    localparam int LAT_MAX = (MUL_LAT > RES_LAT) ? MUL_LAT : RES_LAT;
    localparam int CW      = $clog2(LAT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE_A, S_GAP, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t state, state_nxt;

    logic                dec_a_only, dec_b_only, dec_illegal, dec_mul, dec_split;
    logic [OP_WIDTH-1:0] dec_opa, dec_opb;
    logic [1:0]          dec_iv;

    logic                mode_q, cin_q, ill_q;
    logic [3:0]          cmd_q;
    logic [OP_WIDTH-1:0] opa_q, opb_q;
    logic [1:0]          iv_q;
    logic [CW-1:0]       lat_q, cnt;
`ifdef ALU_SEQ_SPLIT_GAP_EN
    logic [3:0]          gap_q;
`endif

    logic                src_mode, src_cin;
    logic [3:0]          src_cmd;
    logic [OP_WIDTH-1:0] src_opa, src_opb;
    logic [1:0]          src_iv;

    logic                ce_nxt, mode_nxt, cin_nxt;
    logic [3:0]          cmd_nxt;
    logic [OP_WIDTH-1:0] opa_nxt, opb_nxt;
    logic [1:0]          iv_nxt;

    always_comb begin
        dec_a_only  = REQ_MODE ? (REQ_CMD == 4'd4 || REQ_CMD == 4'd5)
                               : (REQ_CMD == 4'd6 || REQ_CMD == 4'd8 || REQ_CMD == 4'd9);
        dec_b_only  = REQ_MODE ? (REQ_CMD == 4'd6 || REQ_CMD == 4'd7)
                               : (REQ_CMD == 4'd7 || REQ_CMD == 4'd10 || REQ_CMD == 4'd11);
        dec_illegal = REQ_MODE ? (REQ_CMD >= 4'd13) : (REQ_CMD >= 4'd14);
        dec_mul     = REQ_MODE && (REQ_CMD == 4'd9 || REQ_CMD == 4'd10);
        dec_split   = REQ_SPLIT && !dec_a_only && !dec_b_only && !dec_illegal;
        dec_opa     = dec_b_only ? '0 : REQ_OPA;
        dec_opb     = dec_a_only ? '0 : REQ_OPB;
        dec_iv      = dec_a_only ? 2'b01 : (dec_b_only ? 2'b10 : 2'b11);
    end

    // Drive registers are loaded from the next state, so on the accept edge the fields come straight from REQ_*.
    always_comb begin
        if (state == S_IDLE) begin
            src_mode = REQ_MODE;
            src_cin  = REQ_CIN;
            src_cmd  = REQ_CMD;
            src_opa  = dec_opa;
            src_opb  = dec_opb;
            src_iv   = dec_iv;
        end else begin
            src_mode = mode_q;
            src_cin  = cin_q;
            src_cmd  = cmd_q;
            src_opa  = opa_q;
            src_opb  = opb_q;
            src_iv   = iv_q;
        end
    end

    always_comb begin
        state_nxt = state;
        ce_nxt    = 1'b0;
        mode_nxt  = 1'b0;
        cin_nxt   = 1'b0;
        cmd_nxt   = '0;
        opa_nxt   = '0;
        opb_nxt   = '0;
        iv_nxt    = 2'b00;

        case (state)
            S_IDLE:    if (REQ_VALID) state_nxt = dec_split ? S_ISSUE_A : S_ISSUE;
`ifdef ALU_SEQ_SPLIT_GAP_EN
            S_ISSUE_A: state_nxt = (gap_q != 4'd0) ? S_GAP : S_ISSUE;
            S_GAP:     if (gap_q == 4'd1) state_nxt = S_ISSUE;
`else
            S_ISSUE_A: state_nxt = S_ISSUE;
`endif
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT:    if (cnt == '0) state_nxt = S_RESP;
            S_RESP:    if (RSP_READY) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        case (state_nxt)
            S_ISSUE_A, S_GAP, S_ISSUE: begin
                ce_nxt   = 1'b1;
                mode_nxt = src_mode;
                cin_nxt  = src_cin;
                cmd_nxt  = src_cmd;
                opa_nxt  = src_opa;
                if (state_nxt == S_ISSUE_A) iv_nxt = 2'b01;
                if (state_nxt == S_ISSUE) begin
                    opb_nxt = src_opb;
                    iv_nxt  = src_iv;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        REQ_READY = (state == S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CE          <= 1'b0;
            MODE        <= 1'b0;
            CIN         <= 1'b0;
            CMD         <= '0;
            OPA         <= '0;
            OPB         <= '0;
            INP_VALID   <= 2'b00;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            ill_q       <= 1'b0;
            cmd_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            iv_q        <= 2'b00;
            lat_q       <= '0;
            cnt         <= '0;
`ifdef ALU_SEQ_SPLIT_GAP_EN
            gap_q       <= '0;
`endif
            RSP_VALID   <= 1'b0;
            RSP_RES     <= '0;
            RSP_FLAGS   <= '0;
            RSP_ILLEGAL <= 1'b0;
        end else begin
            CE        <= ce_nxt;
            MODE      <= mode_nxt;
            CIN       <= cin_nxt;
            CMD       <= cmd_nxt;
            OPA       <= opa_nxt;
            OPB       <= opb_nxt;
            INP_VALID <= iv_nxt;

            if (state == S_IDLE && REQ_VALID) begin
                mode_q <= REQ_MODE;
                cin_q  <= REQ_CIN;
                cmd_q  <= REQ_CMD;
                opa_q  <= dec_opa;
                opb_q  <= dec_opb;
                iv_q   <= dec_iv;
                ill_q  <= dec_illegal;
                lat_q  <= dec_mul ? CW'(MUL_LAT) : CW'(RES_LAT);
`ifdef ALU_SEQ_SPLIT_GAP_EN
                gap_q  <= dec_split ? REQ_GAP : 4'd0;
`endif
            end

`ifdef ALU_SEQ_SPLIT_GAP_EN
            if (state == S_GAP) gap_q <= gap_q - 4'd1;
`endif

            // Loading LAT (not LAT-1) at e0 makes the count-zero capture land on e0+LAT+1, one edge after the ALU update.
            if (state == S_ISSUE)                  cnt <= lat_q;
            else if (state == S_WAIT && cnt != '0) cnt <= cnt - CW'(1);

            if (state == S_WAIT && cnt == '0) begin
                RSP_VALID   <= 1'b1;
                RSP_RES     <= RES;
                RSP_FLAGS   <= {ERR, OFLOW, COUT, G, E, L};
                RSP_ILLEGAL <= ill_q;
            end else if (state == S_RESP && RSP_READY) begin
                RSP_VALID   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_txn_sequencer.sv
// Directed bench for alu_txn_sequencer with a small ALU model whose result is valid for one cycle only.
module tb_alu_txn_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ_VALID, REQ_READY, REQ_MODE, REQ_CIN, REQ_SPLIT;
    logic [3:0]  REQ_CMD;
    logic [7:0]  REQ_OPA, REQ_OPB;
`ifdef ALU_SEQ_SPLIT_GAP_EN
    logic [3:0]  REQ_GAP;
`endif
    logic        CE, MODE, CIN;
    logic [3:0]  CMD;
    logic [7:0]  OPA, OPB;
    logic [1:0]  INP_VALID;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, E, L, ERR;
    logic        RSP_VALID, RSP_READY, RSP_ILLEGAL;
    logic [15:0] RSP_RES;
    logic [5:0]  RSP_FLAGS;

    alu_txn_sequencer #(.OP_WIDTH(8), .RES_LAT(2), .MUL_LAT(3)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_MODE(REQ_MODE), .REQ_CMD(REQ_CMD),
        .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CIN(REQ_CIN), .REQ_SPLIT(REQ_SPLIT),
`ifdef ALU_SEQ_SPLIT_GAP_EN
        .REQ_GAP(REQ_GAP),
`endif
        .CE(CE), .MODE(MODE), .CIN(CIN), .CMD(CMD), .OPA(OPA), .OPB(OPB), .INP_VALID(INP_VALID),
        .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RES(RSP_RES),
        .RSP_FLAGS(RSP_FLAGS), .RSP_ILLEGAL(RSP_ILLEGAL)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc++;

    // ALU model: returns {RES, ERR, OFLOW, COUT, G, E, L}
    function automatic logic [21:0] alu_f(input logic m, input logic [3:0] c,
                                          input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [15:0] r, a16, b16;
        logic        er, ov, co, gg, ee, ll;
        r = '0; er = 1'b0; ov = 1'b0; co = 1'b0; gg = 1'b0; ee = 1'b0; ll = 1'b0;
        a16 = {8'h00, a};
        b16 = {8'h00, b};
        if (m) begin
            case (c)
                4'd0:  begin r = a16 + b16; co = r[8]; end
                4'd1:  begin r = a16 - b16; ov = (a < b); end
                4'd2:  begin r = a16 + b16 + {15'h0, ci}; co = r[8]; end
                4'd3:  begin r = a16 - b16 - {15'h0, ci}; ov = (a16 < b16 + {15'h0, ci}); end
                4'd4:  begin r = a16 + 16'd1; co = r[8]; end
                4'd5:  r = a16 - 16'd1;
                4'd6:  begin r = b16 + 16'd1; co = r[8]; end
                4'd7:  r = b16 - 16'd1;
                4'd8:  begin gg = (a > b); ee = (a == b); ll = (a < b); end
                4'd9:  r = (a16 + 16'd1) * (b16 + 16'd1);
                4'd10: r = (a16 << 1) * b16;
                default: er = 1'b1;
            endcase
        end else begin
            case (c)
                4'd0:  r = {8'h00, a & b};
                4'd1:  r = {8'h00, ~(a & b)};
                4'd2:  r = {8'h00, a | b};
                4'd3:  r = {8'h00, ~(a | b)};
                4'd4:  r = {8'h00, a ^ b};
                4'd5:  r = {8'h00, ~(a ^ b)};
                4'd6:  r = {8'h00, ~a};
                4'd7:  r = {8'h00, ~b};
                4'd8:  r = {8'h00, a >> 1};
                4'd9:  r = {8'h00, a << 1};
                4'd10: r = {8'h00, b >> 1};
                4'd11: r = {8'h00, b << 1};
                4'd12, 4'd13: begin
                    if (|b[7:4]) er = 1'b1;
                    else if (c == 4'd12) r = {8'h00, (a << b[2:0]) | (a >> (4'd8 - {1'b0, b[2:0]}))};
                    else r = {8'h00, (a >> b[2:0]) | (a << (4'd8 - {1'b0, b[2:0]}))};
                end
                default: er = 1'b1;
            endcase
        end
        return {r, er, ov, co, gg, ee, ll};
    endfunction

    int          pend = 0;
    logic [21:0] pval;

    // Result is valid only between edge e0+LAT and edge e0+LAT+1; garbage otherwise.
    always @(posedge CLK) begin
        {RES, ERR, OFLOW, COUT, G, E, L} <= {16'hDEAD, 6'h3F};
        if (pend == 1) {RES, ERR, OFLOW, COUT, G, E, L} <= pval;
        if (pend > 0) pend <= pend - 1;
        if (CE && INP_VALID != 2'b00) begin
            pval <= alu_f(MODE, CMD, OPA, OPB, CIN);
            pend <= (MODE && (CMD == 4'd9 || CMD == 4'd10)) ? 3 : 2;
        end
    end

    int         ce_n, gap_n, last_ce, rsp_cyc;
    logic [3:0] iv_seq, fcmd;
    logic [7:0] fa, fb;
    logic       fmode, fcin;

    always @(negedge CLK) begin
        if (CE) begin
            if (INP_VALID != 2'b00) begin
                if (ce_n == 0) begin
                    fa = OPA; fb = OPB; fcmd = CMD; fmode = MODE; fcin = CIN;
                end
                iv_seq  = {iv_seq[1:0], INP_VALID};
                ce_n++;
                last_ce = cyc;
            end else begin
                gap_n++;
            end
        end
        if (RSP_VALID && rsp_cyc < 0) rsp_cyc = cyc;
    end

    task automatic mon_clear();
        ce_n = 0; gap_n = 0; last_ce = 0; rsp_cyc = -1;
        iv_seq = '0; fa = '0; fb = '0; fcmd = '0; fmode = 1'b0; fcin = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_rsp(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge CLK); #1;
            if (RSP_VALID) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: rsp_timeout got no RSP_VALID want RSP_VALID within 40 cycles", nm);
        end
    endtask

    task automatic drive_req(input logic m, input logic [3:0] c, input logic [7:0] a,
                             input logic [7:0] b, input logic ci, input logic s);
        REQ_MODE = m; REQ_CMD = c; REQ_OPA = a; REQ_OPB = b; REQ_CIN = ci; REQ_SPLIT = s;
    endtask

    typedef struct {
        logic mode; logic [3:0] cmd; logic [7:0] opa, opb; logic cin, split;
        logic [3:0] iv; int ce; logic [7:0] fa, fb;
        logic [15:0] res; logic [5:0] fl; logic ill; int lat;
    } vec_t;

    task automatic run_vec(input string nm, input vec_t v, input int gap_exp);
        bit ok;
        mon_clear();
        @(negedge CLK);
        drive_req(v.mode, v.cmd, v.opa, v.opb, v.cin, v.split);
        REQ_VALID = 1'b1;
        chk({nm, "_req_ready"}, REQ_READY, 1);
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        drive_req(~v.mode, v.cmd ^ 4'h3, ~v.opa, ~v.opb, ~v.cin, ~v.split);
        wait_rsp(nm, ok);
        if (ok) begin
            chk({nm, "_res"},   RSP_RES, v.res);
            chk({nm, "_flags"}, RSP_FLAGS, v.fl);
            chk({nm, "_ill"},   RSP_ILLEGAL, v.ill);
            chk({nm, "_ivseq"}, iv_seq, v.iv);
            chk({nm, "_ce_n"},  ce_n, v.ce);
            chk({nm, "_gap_n"}, gap_n, gap_exp);
            chk({nm, "_opa"},   fa, v.fa);
            chk({nm, "_opb"},   fb, v.fb);
            chk({nm, "_cmd"},   fcmd, v.cmd);
            chk({nm, "_mode_cin"}, {fmode, fcin}, {v.mode, v.cin});
            chk({nm, "_lat"},   rsp_cyc - last_ce, v.lat);
        end
        @(posedge CLK); #1;
        chk({nm, "_rsp_drop"}, RSP_VALID, 0);
    endtask

    vec_t vt[13];
    vec_t vill;

    initial begin
        bit ok;
        bit seen;
        // mode cmd opa opb cin split | iv_seq ce_n opa0 opb0 res flags ill lat(ISSUE cycle -> RSP_VALID cycle)
        vt[0]  = '{1'b1, 4'd0,  8'hFF, 8'h01, 1'b0, 1'b0, 4'b0011, 1, 8'hFF, 8'h01, 16'h0100, 6'h08, 1'b0, 4};
        vt[1]  = '{1'b1, 4'd4,  8'h7F, 8'h55, 1'b0, 1'b1, 4'b0001, 1, 8'h7F, 8'h00, 16'h0080, 6'h00, 1'b0, 4};
        vt[2]  = '{1'b1, 4'd1,  8'h05, 8'h09, 1'b0, 1'b1, 4'b0111, 2, 8'h05, 8'h00, 16'hFFFC, 6'h10, 1'b0, 4};
        vt[3]  = '{1'b1, 4'd9,  8'h03, 8'h04, 1'b0, 1'b0, 4'b0011, 1, 8'h03, 8'h04, 16'h0014, 6'h00, 1'b0, 5};
        vt[4]  = '{1'b0, 4'd12, 8'h81, 8'h10, 1'b0, 1'b0, 4'b0011, 1, 8'h81, 8'h10, 16'h0000, 6'h20, 1'b0, 4};
        vt[5]  = '{1'b1, 4'd7,  8'h33, 8'h05, 1'b0, 1'b1, 4'b0010, 1, 8'h00, 8'h05, 16'h0004, 6'h00, 1'b0, 4};
        vt[6]  = '{1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 1'b1, 4'b0111, 2, 8'hF0, 8'h00, 16'h0030, 6'h00, 1'b0, 4};
        vt[7]  = '{1'b1, 4'd15, 8'h12, 8'h34, 1'b0, 1'b1, 4'b0011, 1, 8'h12, 8'h34, 16'h0000, 6'h20, 1'b1, 4};
        vt[8]  = '{1'b1, 4'd8,  8'h10, 8'h20, 1'b0, 1'b0, 4'b0011, 1, 8'h10, 8'h20, 16'h0000, 6'h01, 1'b0, 4};
        vt[9]  = '{1'b1, 4'd10, 8'h02, 8'h03, 1'b0, 1'b1, 4'b0111, 2, 8'h02, 8'h00, 16'h000C, 6'h00, 1'b0, 5};
        vt[10] = '{1'b0, 4'd6,  8'h0F, 8'hAA, 1'b0, 1'b1, 4'b0001, 1, 8'h0F, 8'h00, 16'h00F0, 6'h00, 1'b0, 4};
        vt[11] = '{1'b0, 4'd14, 8'h01, 8'h02, 1'b0, 1'b0, 4'b0011, 1, 8'h01, 8'h02, 16'h0000, 6'h20, 1'b1, 4};
        vt[12] = '{1'b1, 4'd2,  8'hFF, 8'h00, 1'b1, 1'b0, 4'b0011, 1, 8'hFF, 8'h00, 16'h0100, 6'h08, 1'b0, 4};
        vill   = '{1'b1, 4'd15, 8'hAB, 8'hCD, 1'b1, 1'b0, 4'b0011, 1, 8'hAB, 8'hCD, 16'h0000, 6'h20, 1'b1, 4};

        REQ_VALID = 1'b0;
        RSP_READY = 1'b1;
        drive_req(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
`ifdef ALU_SEQ_SPLIT_GAP_EN
        REQ_GAP = 4'd0;
`endif
        mon_clear();

        #1;
        chk("rst_drive", {CE, MODE, CIN, CMD, OPA, OPB, INP_VALID}, 0);
        chk("rst_rsp",   {RSP_VALID, RSP_FLAGS, RSP_ILLEGAL, REQ_READY}, 1);
        chk("rst_res",   RSP_RES, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vt[i], 0);

        // Response held under back-pressure while a second request waits on REQ_VALID.
        mon_clear();
        @(negedge CLK);
        drive_req(1'b1, 4'd0, 8'h10, 8'h20, 1'b0, 1'b0);
        RSP_READY = 1'b0;
        REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        drive_req(1'b1, 4'd5, 8'h40, 8'h77, 1'b0, 1'b0);
        wait_rsp("hold", ok);
        chk("hold_res0", RSP_RES, 16'h0030);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK); #1;
            chk($sformatf("hold_res_c%0d", i),   RSP_RES, 16'h0030);
            chk($sformatf("hold_valid_c%0d", i), RSP_VALID, 1);
            chk($sformatf("hold_ready_c%0d", i), REQ_READY, 0);
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        chk("hold_hs_valid", RSP_VALID, 0);
        chk("hold_hs_idle",  REQ_READY, 1);
        chk("hold_hs_ce",    CE, 0);
        mon_clear();
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        chk("next_acc_ready", REQ_READY, 0);
        chk("next_acc_drive", {CE, INP_VALID, OPA, OPB}, {1'b1, 2'b01, 8'h40, 8'h00});
        wait_rsp("next", ok);
        chk("next_res",   RSP_RES, 16'h003F);
        chk("next_flags", RSP_FLAGS, 6'h00);
        @(posedge CLK); #1;

        // Reset while waiting for the ALU result.
        @(negedge CLK);
        drive_req(1'b1, 4'd9, 8'h05, 8'h06, 1'b0, 1'b0);
        REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        @(posedge CLK);
        @(negedge CLK); #2;
        chk("mid_wait_ce", CE, 0);
        RST_N = 1'b0;
        #1;
        chk("rstw_drive", {CE, MODE, CIN, CMD, OPA, OPB, INP_VALID}, 0);
        chk("rstw_rsp",   {RSP_VALID, RSP_FLAGS, RSP_ILLEGAL, REQ_READY}, 1);
        chk("rstw_res",   RSP_RES, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (RSP_VALID) seen = 1'b1;
        end
        chk("rstw_no_rsp", seen, 0);
        run_vec("ill_after_rst", vill, 0);

`ifdef ALU_SEQ_SPLIT_GAP_EN
        begin
            vec_t vg;
            vg = '{1'b1, 4'd0, 8'h11, 8'h22, 1'b0, 1'b1, 4'b0111, 2, 8'h11, 8'h00, 16'h0033, 6'h00, 1'b0, 4};
            REQ_GAP = 4'd5;
            run_vec("gap5_split", vg, 5);
            vg.split = 1'b0; vg.iv = 4'b0011; vg.ce = 1; vg.fb = 8'h22;
            run_vec("gap5_nosplit", vg, 0);
            REQ_GAP = 4'd0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
